i2c_reg_master: RTL and testbench

I2C_REG_MASTER -- requirements
Module: i2c_reg_master

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_timeout.sv | 31 +++
 rtl/i2c_reg_master.sv | 145 ++++++++++++++
 tb/tb_i2c_reg_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register master: controller states and
// the result codes reported on resp_err.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LAUNCH,
        DEV_W,
        REG,
        WDATA,
        RSTART,
        DEV_R,
        RDATA,
        STOP_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_ARB     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/i2c_timeout.sv
// Saturating progress watchdog: counts idle cycles while enabled and flags
// expiry on the cycle whose clock edge brings the count to LIMIT.
module i2c_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // NOTE: sequential state is only ever assigned with <= so every flop sees pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != W'(LIMIT)) begin
            count <= count + W'(1);
        end
    end

    // Looks one count ahead so the abort lands on the same edge the count reaches LIMIT.
    assign expired = enable && !clear && (count >= W'(LIMIT - 1));

endmodule

// File: rtl/i2c_reg_master.sv
// Register-access front end for an i2c_core: turns one read/write request
// into the DEV/REG/DATA byte sequence and reports a single result code.
module i2c_reg_master
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [1:0] resp_err,
    output logic [7:0] resp_rdata,
    output logic       transfer_start,
    output logic       transfer_continues,
    output logic       mode,
    output logic [7:0] data_tx,
    input  logic       transfer_ready,
    input  logic       transaction_complete,
    input  logic       nack,
    input  logic       start_err,
    input  logic       arbitration_err,
    input  logic [7:0] data_rx
);

    state_t     state;
    logic       rd;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;

    logic wd_enable;
    logic wd_clear;
    logic wd_expired;
    logic abort_arb;
    logic nack_hit;

    assign req_ready = (state == IDLE);
    assign wd_enable = (state != IDLE) && (state != RESP);
    // Every state entry coincides with IDLE or a core progress input, so those alone restart the count.
    assign wd_clear  = !wd_enable || transaction_complete || transfer_ready;
    assign abort_arb = wd_enable && (start_err || arbitration_err);
    assign nack_hit  = transaction_complete && nack && (state inside {DEV_W, REG, WDATA, DEV_R});

    i2c_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_in  (clk_in),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // NOTE: the latched request fields are reset as well; they are plain registers, not a memory array.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            rd                 <= 1'b0;
            dev                <= '0;
            reg_addr           <= '0;
            wdata              <= '0;
            transfer_start     <= 1'b0;
            transfer_continues <= 1'b0;
            mode               <= 1'b0;
            data_tx            <= '0;
            resp_valid         <= 1'b0;
            resp_err           <= ERR_OK;
            resp_rdata         <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (abort_arb || wd_expired) begin
                transfer_start <= 1'b0;
                if (resp_err == ERR_OK) resp_err <= abort_arb ? ERR_ARB : ERR_TIMEOUT;
                if (!rd) resp_rdata <= '0;
                resp_valid <= 1'b1;
                state      <= RESP;
            end else if (nack_hit) begin
                transfer_start <= 1'b0;
                if (resp_err == ERR_OK) resp_err <= ERR_NACK;
                state <= STOP_WAIT;
            end else begin
                case (state)
                    IDLE: if (req_valid) begin
                        rd                 <= req_read;
                        dev                <= req_dev_addr;
                        reg_addr           <= req_reg_addr;
                        wdata              <= req_wdata;
                        transfer_start     <= 1'b1;
                        transfer_continues <= 1'b1;
                        mode               <= 1'b0;
                        data_tx            <= {req_dev_addr, 1'b0};
                        resp_err           <= ERR_OK;
                        state              <= LAUNCH;
                    end
                    LAUNCH: if (transfer_start && transfer_ready) state <= DEV_W;
                    DEV_W: if (transaction_complete) begin
                        data_tx            <= reg_addr;
                        mode               <= 1'b0;
                        transfer_continues <= !rd;
                        state              <= REG;
                    end
                    REG: if (transaction_complete) begin
                        mode <= 1'b0;
                        if (rd) begin
                            transfer_start     <= 1'b1;
                            data_tx            <= {dev, 1'b1};
                            transfer_continues <= 1'b1;
                            state              <= RSTART;
                        end else begin
                            transfer_start     <= 1'b0;
                            data_tx            <= wdata;
                            transfer_continues <= 1'b0;
                            state              <= WDATA;
                        end
                    end
                    WDATA:  if (transaction_complete) state <= STOP_WAIT;
                    RSTART: if (transaction_complete) state <= DEV_R;
                    DEV_R: if (transaction_complete) begin
                        transfer_start     <= 1'b0;
                        transfer_continues <= 1'b0;
                        mode               <= 1'b1;
                        state              <= RDATA;
                    end
                    // The last read byte is always NACKed by the master, so nack is not an error here.
                    RDATA: if (transaction_complete) begin
                        resp_rdata <= data_rx;
                        state      <= STOP_WAIT;
                    end
                    STOP_WAIT: if (transfer_ready) begin
                        if (!rd) resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                    RESP:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed bench for i2c_reg_master: a per-cycle table drives the core-side
// handshakes, plus hand-written watchdog and mid-transfer reset sequences.
module tb_i2c_reg_master;

    logic       clk_in;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_read;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [1:0] resp_err;
    logic [7:0] resp_rdata;
    logic       transfer_start;
    logic       transfer_continues;
    logic       mode;
    logic [7:0] data_tx;
    logic       transfer_ready;
    logic       transaction_complete;
    logic       nack;
    logic       start_err;
    logic       arbitration_err;
    logic [7:0] data_rx;

    i2c_reg_master #(.TIMEOUT_CYCLES(100)) dut (
        .clk_in               (clk_in),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_read             (req_read),
        .req_dev_addr         (req_dev_addr),
        .req_reg_addr         (req_reg_addr),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_err             (resp_err),
        .resp_rdata           (resp_rdata),
        .transfer_start       (transfer_start),
        .transfer_continues   (transfer_continues),
        .mode                 (mode),
        .data_tx              (data_tx),
        .transfer_ready       (transfer_ready),
        .transaction_complete (transaction_complete),
        .nack                 (nack),
        .start_err            (start_err),
        .arbitration_err      (arbitration_err),
        .data_rx              (data_rx)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One clock of stimulus and the outputs expected just after that edge.
    typedef struct {
        logic       valid;
        logic       read;
        logic [7:0] reg_addr;
        logic       trdy;
        logic       tc;
        logic       nk;
        logic       serr;
        logic       aerr;
        logic [7:0] rx;
        logic       e_ready;
        logic       e_start;
        logic       e_cont;
        logic       e_mode;
        logic [7:0] e_tx;
        logic       e_rv;
        logic [1:0] e_err;
        logic [7:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input int val, input int rd, input int ra, input int trdy,
                               input int tc, input int nk, input int se, input int ae, input int rx,
                               input int rdy, input int st, input int ct, input int md, input int tx,
                               input int rv, input int er, input int rdat);
        vec_t r;
        r.valid   = val[0];
        r.read    = rd[0];
        r.reg_addr = ra[7:0];
        r.trdy    = trdy[0];
        r.tc      = tc[0];
        r.nk      = nk[0];
        r.serr    = se[0];
        r.aerr    = ae[0];
        r.rx      = rx[7:0];
        r.e_ready = rdy[0];
        r.e_start = st[0];
        r.e_cont  = ct[0];
        r.e_mode  = md[0];
        r.e_tx    = tx[7:0];
        r.e_rv    = rv[0];
        r.e_err   = er[1:0];
        r.e_rdata = rdat[7:0];
        return r;
    endfunction

    task automatic idle_inputs();
        req_valid            = 1'b0;
        req_read             = 1'b0;
        req_reg_addr         = 8'h00;
        transfer_ready       = 1'b0;
        transaction_complete = 1'b0;
        nack                 = 1'b0;
        start_err            = 1'b0;
        arbitration_err      = 1'b0;
        data_rx              = 8'h00;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".transfer_start"}, transfer_start, 0);
        check({name, ".transfer_continues"}, transfer_continues, 0);
        check({name, ".mode"}, mode, 0);
        check({name, ".data_tx"}, data_tx, 0);
        check({name, ".resp_valid"}, resp_valid, 0);
        check({name, ".resp_err"}, resp_err, 0);
        check({name, ".resp_rdata"}, resp_rdata, 0);
    endtask

    task automatic run_vectors();
        for (int i = 0; i < vecs.size(); i++) begin
            req_valid            = vecs[i].valid;
            req_read             = vecs[i].read;
            req_reg_addr         = vecs[i].reg_addr;
            transfer_ready       = vecs[i].trdy;
            transaction_complete = vecs[i].tc;
            nack                 = vecs[i].nk;
            start_err            = vecs[i].serr;
            arbitration_err      = vecs[i].aerr;
            data_rx              = vecs[i].rx;
            @(posedge clk_in);
            #1;
            check($sformatf("vec%0d.req_ready", i), req_ready, vecs[i].e_ready);
            check($sformatf("vec%0d.transfer_start", i), transfer_start, vecs[i].e_start);
            check($sformatf("vec%0d.transfer_continues", i), transfer_continues, vecs[i].e_cont);
            check($sformatf("vec%0d.mode", i), mode, vecs[i].e_mode);
            check($sformatf("vec%0d.data_tx", i), data_tx, vecs[i].e_tx);
            check($sformatf("vec%0d.resp_valid", i), resp_valid, vecs[i].e_rv);
            check($sformatf("vec%0d.resp_err", i), resp_err, vecs[i].e_err);
            check($sformatf("vec%0d.resp_rdata", i), resp_rdata, vecs[i].e_rdata);
        end
        idle_inputs();
    endtask

    // Start a request, let it reach a mid-transfer state, then pulse reset between edges.
    task automatic reset_mid(input string name, input logic rd, input int n_tc, input logic [7:0] pre_tx);
        int rv_seen;
        req_valid    = 1'b1;
        req_read     = rd;
        req_reg_addr = 8'h10;
        @(posedge clk_in); #1;
        req_valid      = 1'b0;
        transfer_ready = 1'b1;
        @(posedge clk_in); #1;
        transfer_ready = 1'b0;
        for (int k = 0; k < n_tc; k++) begin
            transaction_complete = 1'b1;
            @(posedge clk_in); #1;
        end
        transaction_complete = 1'b0;
        check({name, ".pre_data_tx"}, data_tx, pre_tx);
        #2 reset = 1'b1;
        #1 check_outputs_zero({name, ".async"});
        #2 reset = 1'b0;
        @(posedge clk_in); #1;
        check({name, ".req_ready_after"}, req_ready, 1);
        rv_seen = 0;
        transfer_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            transaction_complete = k[0];
            @(posedge clk_in); #1;
            if (resp_valid) rv_seen++;
        end
        check({name, ".no_resp"}, rv_seen, 0);
        idle_inputs();
    endtask

    initial begin
        int cycles;
        reset        = 1'b1;
        req_dev_addr = 7'h50;
        req_wdata    = 8'hA5;
        idle_inputs();

        repeat (2) @(posedge clk_in);
        #1;
        check("reset.req_ready", req_ready, 1);
        check_outputs_zero("reset");
        #4 reset = 1'b0;
        @(posedge clk_in); #1;
        check("reset.req_ready_first_cycle", req_ready, 1);

        //         val rd reg   trdy tc nk se ae rx     rdy st ct md tx     rv er rdata
        // read dev 0x50 reg 0x02, slave returns 0x3C (nack on the last byte is expected)
        vecs.push_back(v(1, 1, 'h02, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 1, 0, 0, 'h02, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA1, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA1, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 0, 0, 1, 'hA1, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 1, 0, 0, 'h3C,  0, 0, 0, 1, 'hA1, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 0, 0, 1, 'hA1, 1, 0, 'h3C));
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  1, 0, 0, 1, 'hA1, 0, 0, 'h3C));
        // write dev 0x50 reg 0x10 data 0xA5, all ACK
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 1, 1, 0, 'h10, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 0, 0, 0, 'hA5, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 0, 0, 0, 'hA5, 0, 0, 'h3C));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 0, 0, 0, 'hA5, 1, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  1, 0, 0, 0, 'hA5, 0, 0, 'h00));
        // address NACK on the first byte, response only after transfer_ready
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 'hA0, 0, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  0, 0, 1, 0, 'hA0, 0, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  0, 0, 1, 0, 'hA0, 0, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 0, 1, 0, 'hA0, 1, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  1, 0, 1, 0, 'hA0, 0, 1, 'h00));
        // NACK then arbitration loss while waiting for STOP: first error is kept
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 1, 0, 0, 'h00,  0, 0, 1, 0, 'hA0, 0, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 1, 'h00,  0, 0, 1, 0, 'hA0, 1, 1, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  1, 0, 1, 0, 'hA0, 0, 1, 'h00));
        // arbitration_err during the REG byte, no wait for transfer_ready
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 0, 0, 'h00,  0, 1, 1, 0, 'h10, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 1, 'h00,  0, 0, 1, 0, 'h10, 1, 2, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  1, 0, 1, 0, 'h10, 0, 2, 'h00));
        // start_err together with transaction_complete: ARB wins, byte does not advance
        vecs.push_back(v(1, 0, 'h10, 0, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 1, 0, 0, 0, 0, 'h00,  0, 1, 1, 0, 'hA0, 0, 0, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 1, 0, 1, 0, 'h00,  0, 0, 1, 0, 'hA0, 1, 2, 'h00));
        vecs.push_back(v(0, 0, 'h00, 0, 0, 0, 0, 0, 'h00,  1, 0, 1, 0, 'hA0, 0, 2, 'h00));
        run_vectors();

        // Watchdog: last progress is the transfer_ready that enters DEV_W.
        req_valid    = 1'b1;
        req_read     = 1'b0;
        req_reg_addr = 8'h10;
        @(posedge clk_in); #1;
        req_valid      = 1'b0;
        transfer_ready = 1'b1;
        @(posedge clk_in); #1;
        transfer_ready = 1'b0;
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk_in); #1;
            cycles++;
            if (resp_valid) break;
        end
        check("timeout.cycles", cycles, 100);
        check("timeout.resp_err", resp_err, 3);
        check("timeout.transfer_start", transfer_start, 0);
        @(posedge clk_in); #1;
        check("timeout.req_ready", req_ready, 1);

        reset_mid("reset_wdata", 1'b0, 2, 8'hA5);
        reset_mid("reset_rstart", 1'b1, 2, 8'hA1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
